// File: rtl/mm_queued.sv
`default_nettype none
// =============================================================================
// mm_queued : line memory behind an in-order request FIFO; fixed read latency,
//             fixed per-write engine occupancy, byte-enable merge on writes.
// Rev 1.0
// =============================================================================
module mm_queued #(
  parameter int ENTRIES    = 1024,
  parameter int LINE_BITS  = 256,
  parameter int READ_LAT   = 4,
  parameter int WRITE_TPUT = 4,
  parameter int QDEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            a,
  input  logic [LINE_BITS/8-1:0] be,
  input  logic [LINE_BITS-1:0]   wd,
  input  logic                   read,
  input  logic                   write,
  output logic                   ready,
  output logic [LINE_BITS-1:0]   rd,
  output logic                   valid,
  output logic                   err
);
  localparam int BEW  = LINE_BITS / 8;
  localparam int OFS  = $clog2(BEW);
  localparam int AW   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW   = $clog2(QDEPTH + 1);
  localparam int TMAX = (READ_LAT > WRITE_TPUT) ? READ_LAT : WRITE_TPUT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  if (READ_LAT < 1 || WRITE_TPUT < 1 || QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_params
    $fatal(1, "mm_queued: READ_LAT/WRITE_TPUT must be >= 1 and QDEPTH a power of 2 >= 2");
  end

  typedef struct packed {
    logic                 wr;
    logic                 oor;
    logic [AW-1:0]        idx;
    logic [BEW-1:0]       be;
    logic [LINE_BITS-1:0] wd;
  } req_t;

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_BUSY = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  req_t                 cur_q, cur_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 mrg_q, mrg_d;
  logic [LINE_BITS-1:0] rd_q, rd_d;
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;

  req_t                 fifo_q [QDEPTH];
  logic [LINE_BITS-1:0] mem_q  [ENTRIES];

  logic [31:0]          line_idx;
  logic                 in_range, accept, fifo_empty, head_avail, store, pop;
  req_t                 push_req, head;
  logic [LINE_BITS-1:0] be_mask;

  assign line_idx   = a >> OFS;
  assign in_range   = line_idx < 32'(ENTRIES);
  assign ready      = (count_q < CW'(QDEPTH)) & ~reset;
  assign accept     = (read | write) & ready;
  assign fifo_empty = (count_q == '0);
  assign head_avail = ~fifo_empty | accept;
  // An idle engine takes a request straight from the inputs when the FIFO is empty
  assign head       = fifo_empty ? push_req : fifo_q[rptr_q];
  assign store      = accept & ~(pop & fifo_empty);

  always_comb begin
    push_req     = '0;
    push_req.wr  = write;
    push_req.oor = ~in_range;
    push_req.idx = line_idx[AW-1:0];
    push_req.be  = be;
    push_req.wd  = wd;
  end

  always_comb begin
    wptr_d  = wptr_q + PW'(store);
    rptr_d  = rptr_q + PW'(pop & ~fifo_empty);
    count_d = count_q + CW'(store) - CW'(pop & ~fifo_empty);
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cur_d   = cur_q;
    valid_d = 1'b0;
    rd_d    = rd_q;
    mrg_d   = 1'b0;
    pop     = 1'b0;
    err_d   = accept & ((read & write) | ~in_range);
    case (state_q)
      IDLE: pop = head_avail;
      RD_WAIT: begin
        if (tmr_q == '0) begin
          valid_d = 1'b1;
          rd_d    = cur_q.oor ? '0 : mem_q[cur_q.idx];
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      WR_BUSY: begin
        // Chaining straight into the next request sustains one write per WRITE_TPUT cycles
        if (tmr_q == '0) begin
          pop     = head_avail;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      cur_d   = head;
      state_d = head.wr ? WR_BUSY : RD_WAIT;
      tmr_d   = head.wr ? TW'(WRITE_TPUT - 1) : TW'(READ_LAT - 1);
      mrg_d   = head.wr & ~head.oor;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cur_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      mrg_q   <= 1'b0;
      rd_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      mrg_q   <= mrg_d;
      rd_q    <= rd_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) fifo_q[wptr_q] <= push_req;
  end

  for (genvar i = 0; i < BEW; i++) begin : g_be_mask
    assign be_mask[i*8 +: 8] = {8{cur_q.be[i]}};
  end

  // A merge already scheduled completes even if reset arrives on that edge
  always_ff @(posedge clk) begin
    if (mrg_q && cur_q.wr) mem_q[cur_q.idx] <= (mem_q[cur_q.idx] & ~be_mask) | (cur_q.wd & be_mask);
  end

  assign rd    = rd_q;
  assign valid = valid_q;
  assign err   = err_q;
endmodule
`default_nettype wire
